// File: rtl/alu_wb_stage_if.sv
// EX->WB stage bus: EX op handshake, load data return,
// register-file write port and pending-load tag.
interface alu_wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              ex_valid;
    logic              ex_ready;
    logic [1:0]        ex_wb_sel;
    logic [REG_AW-1:0] ex_rd;
    logic [XLEN-1:0]   ex_alu_result;
    logic [XLEN-1:0]   ex_pc;
    logic [2:0]        ex_funct3;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              ld_pending;
    logic [REG_AW-1:0] ld_rd;

    modport master (
        output ex_valid, ex_wb_sel, ex_rd,
        output ex_alu_result, ex_pc, ex_funct3,
        output mem_rvalid, mem_rdata,
        input  ex_ready, rf_we, rf_waddr, rf_wdata,
        input  ld_pending, ld_rd
    );

    modport slave (
        input  ex_valid, ex_wb_sel, ex_rd,
        input  ex_alu_result, ex_pc, ex_funct3,
        input  mem_rvalid, mem_rdata,
        output ex_ready, rf_we, rf_waddr, rf_wdata,
        output ld_pending, ld_rd
    );
endinterface

// File: rtl/alu_wb_stage.sv
// EX->WB stage: selects ALU/pc+4/load writeback, waits for load
// data and extends it, drives the register-file write port.
module alu_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         rst,
    alu_wb_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_ld_pend;
    logic [REG_AW-1:0] r_ld_rd;
    logic [2:0]        r_ld_f3;
    logic [1:0]        r_ld_off;

    logic              w_ex_ready;
    logic              w_accept;
    logic              w_ld_start;
    logic              w_ld_done;
    logic              w_we_nxt;
    logic [REG_AW-1:0] w_waddr_nxt;
    logic [XLEN-1:0]   w_wdata_nxt;
    logic [XLEN-1:0]   w_ld_data;

    function automatic logic [XLEN-1:0] f_extend(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  f_extend = {{(XLEN-8){b[7]}}, b};
            3'b100:  f_extend = {{(XLEN-8){1'b0}}, b};
            3'b001:  f_extend = {{(XLEN-16){h[15]}}, h};
            3'b101:  f_extend = {{(XLEN-16){1'b0}}, h};
            default: f_extend = d;
        endcase
    endfunction

    assign w_ld_data = f_extend(r_ld_f3, r_ld_off, bus.mem_rdata);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_WRITE: begin
                if (!w_accept)
                    w_state_nxt = S_IDLE;
                else if (bus.ex_wb_sel == 2'b10)
                    w_state_nxt = S_WAIT;
                else
                    w_state_nxt = S_WRITE;
            end
            S_WAIT: begin
                if (bus.mem_rvalid) w_state_nxt = S_WRITE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ex_ready  = (r_state != S_WAIT);
        w_accept    = bus.ex_valid & w_ex_ready;
        w_ld_start  = w_accept & (bus.ex_wb_sel == 2'b10);
        w_ld_done   = (r_state == S_WAIT) & bus.mem_rvalid;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        if (w_ld_done) begin
            if (r_ld_rd != '0) begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_ld_rd;
                w_wdata_nxt = w_ld_data;
            end
        end else if (w_accept && bus.ex_rd != '0) begin
            // no-writeback and load ops leave the port idle here
            unique case (bus.ex_wb_sel)
                2'b00: begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = bus.ex_rd;
                    w_wdata_nxt = bus.ex_alu_result;
                end
                2'b01: begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = bus.ex_rd;
                    w_wdata_nxt = bus.ex_pc + XLEN'(4);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_ld_pend <= 1'b0;
            r_ld_rd   <= '0;
            r_ld_f3   <= '0;
            r_ld_off  <= '0;
        end else begin
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            if (w_ld_start) begin
                r_ld_pend <= (bus.ex_rd != '0);
                r_ld_rd   <= bus.ex_rd;
                r_ld_f3   <= bus.ex_funct3;
                r_ld_off  <= bus.ex_alu_result[1:0];
            end else if (w_ld_done) begin
                r_ld_pend <= 1'b0;
                r_ld_rd   <= '0;
            end
        end
    end

    assign bus.ex_ready   = w_ex_ready;
    assign bus.rf_we      = r_we;
    assign bus.rf_waddr   = r_waddr;
    assign bus.rf_wdata   = r_wdata;
    assign bus.ld_pending = r_ld_pend;
    assign bus.ld_rd      = r_ld_rd;
endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed cases then
// randomized ops against a behavioural writeback model.
module tb_alu_wb_stage;
    logic clk;
    logic rst;

    alu_wb_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    alu_wb_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t         exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          negcnt  = 0;
    logic [4:0]  last_a  = '0;
    logic [31:0] last_d  = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Reference load extension from byte/half arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input int off,
                                             input logic [31:0] w);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        wr_t it;
        negcnt++;
        if (rst) begin
            last_a = '0;
            last_d = '0;
        end else if (bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_write actual=%0d:%h required=none",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                it = exp_q.pop_front();
                chk("wb_cycle", negcnt, it.c);
                chk("waddr", {27'd0, bus.rf_waddr}, {27'd0, it.a});
                chk("wdata", bus.rf_wdata, it.d);
                last_a = it.a;
                last_d = it.d;
            end
        end else begin
            chk("rf_we", {31'd0, bus.rf_we}, 32'd0);
            chk("hold_waddr", {27'd0, bus.rf_waddr}, {27'd0, last_a});
            chk("hold_wdata", bus.rf_wdata, last_d);
        end
    end

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t it;
        it.a = a;
        it.d = d;
        it.c = negcnt + 1;
        exp_q.push_back(it);
    endtask

    task automatic do_op(input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] f3, input int waitn,
                         input logic [31:0] rdata);
        int n;
        bus.ex_valid      = 1'b1;
        bus.ex_wb_sel     = sel;
        bus.ex_rd         = rd;
        bus.ex_alu_result = alu;
        bus.ex_pc         = pc;
        bus.ex_funct3     = f3;
        bus.mem_rvalid    = ($urandom_range(0, 3) == 0);
        bus.mem_rdata     = $urandom;
        n = 0;
        while (bus.ex_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_accept", {31'd0, bus.ex_ready}, 32'd1);
        @(posedge clk);
        if (rd != 0 && sel == 2'b00) push(rd, alu);
        if (rd != 0 && sel == 2'b01) push(rd, pc + 32'd4);
        #1;
        bus.ex_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (sel == 2'b10) begin
            for (int i = 0; i < waitn; i++) begin
                chk("wait_ready", {31'd0, bus.ex_ready}, 32'd0);
                chk("wait_ld_pending", {31'd0, bus.ld_pending},
                    {31'd0, rd != 0});
                chk("wait_ld_rd", {27'd0, bus.ld_rd}, {27'd0, rd});
                bus.ex_valid      = $urandom_range(0, 1);
                bus.ex_wb_sel     = 2'b00;
                bus.ex_rd         = 5'd31;
                bus.ex_alu_result = $urandom;
                @(posedge clk);
                #1;
            end
            chk("wait_ready", {31'd0, bus.ex_ready}, 32'd0);
            bus.ex_valid   = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            @(posedge clk);
            if (rd != 0) push(rd, ref_load(f3, int'(alu[1:0]), rdata));
            #1;
            bus.mem_rvalid = 1'b0;
            chk("done_ld_pending", {31'd0, bus.ld_pending}, 32'd0);
            chk("done_ld_rd", {27'd0, bus.ld_rd}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [1:0]  sel;
        logic [4:0]  rd;
        rst               = 1'b1;
        bus.ex_valid      = 1'b0;
        bus.ex_wb_sel     = 2'b00;
        bus.ex_rd         = '0;
        bus.ex_alu_result = '0;
        bus.ex_pc         = '0;
        bus.ex_funct3     = '0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("rst_wdata", bus.rf_wdata, 32'd0);
        chk("rst_ld_pending", {31'd0, bus.ld_pending}, 32'd0);
        chk("rst_ld_rd", {27'd0, bus.ld_rd}, 32'd0);
        chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);

        do_op(2'b00, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 0, 32'h0);
        @(posedge clk);
        #1;
        do_op(2'b01, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0, 0, 32'h0);
        do_op(2'b00, 5'd2, 32'hCAFE_0002, 32'h0, 3'd0, 0, 32'h0);
        do_op(2'b10, 5'd3, 32'h1000_0002, 32'h0, 3'b000, 3, 32'h0080_0000);
        do_op(2'b10, 5'd4, 32'h1000_0002, 32'h0, 3'b101, 1, 32'hBEEF_0000);
        do_op(2'b10, 5'd6, 32'h1000_0000, 32'h0, 3'b010, 0, 32'hDEAD_BEEF);
        do_op(2'b00, 5'd0, 32'h5555_AAAA, 32'h0, 3'd0, 0, 32'h0);
        do_op(2'b11, 5'd9, 32'h7777_7777, 32'h0, 3'd0, 0, 32'h0);
        do_op(2'b10, 5'd0, 32'h1000_0001, 32'h0, 3'b000, 2, 32'hFFFF_FFFF);

        do_op(2'b00, 5'd8, 32'hA5A5_A5A5, 32'h0, 3'd0, 0, 32'h0);
        bus.ex_valid      = 1'b1;
        bus.ex_wb_sel     = 2'b10;
        bus.ex_rd         = 5'd7;
        bus.ex_alu_result = 32'h2000_0000;
        bus.ex_funct3     = 3'b010;
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        chk("rstw_ld_rd", {27'd0, bus.ld_rd}, 32'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        chk("rstw_ld_pending", {31'd0, bus.ld_pending}, 32'd0);
        chk("rstw_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
        chk("rstw_rf_we", {31'd0, bus.rf_we}, 32'd0);

        for (int k = 0; k < 300; k++) begin
            sel = 2'($urandom_range(0, 3));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            do_op(sel, rd, $urandom, $urandom, 3'($urandom),
                  $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_rvalid = $urandom_range(0, 1);
                @(posedge clk);
                #1;
                bus.mem_rvalid = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
